// File: rtl/array_update_arbiter.sv
// Two-requester round-robin arbiter feeding a one-stage update pipeline into
// a small register array. An accepted update sits in stage 0 for one cycle
// and is written into the array at the following edge.
module array_update_arbiter #(
    parameter int ELEM_W = 33,
    parameter int N_ELEM = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       req0_valid,
    input  logic [$clog2(N_ELEM)-1:0]  req0_idx,
    input  logic [ELEM_W-1:0]          req0_data,
    output logic                       req0_ready,
    input  logic                       req1_valid,
    input  logic [$clog2(N_ELEM)-1:0]  req1_idx,
    input  logic [ELEM_W-1:0]          req1_data,
    output logic                       req1_ready,
    output logic [ELEM_W*N_ELEM-1:0]   arr_out,
    output logic                       commit_valid,
    output logic [$clog2(N_ELEM)-1:0]  commit_idx,
    output logic [7:0]                 upd_count
);

    localparam int IDX_W = $clog2(N_ELEM);

    logic              ptr;
    logic              grant0;
    logic              grant1;
    logic              s0_valid;
    logic [IDX_W-1:0]  s0_idx;
    logic [ELEM_W-1:0] s0_data;
    logic [ELEM_W-1:0] arr [N_ELEM];
    logic              do_write;

    // Grant selection: a lone requester wins, a tie goes to the pointer.
    // Reset and clear suppress every grant so nothing is accepted then.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && !clear) begin
            if (req0_valid && (!req1_valid || !ptr)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign do_write   = s0_valid && !clear;

    // Priority pointer moves to the loser after a grant, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (grant0) begin
            ptr <= 1'b1;
        end else if (grant1) begin
            ptr <= 1'b0;
        end
    end

    // Stage 0 captures the granted request; clear leaves it empty because
    // clear already blocks every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid <= 1'b0;
            s0_idx   <= '0;
            s0_data  <= '0;
        end else begin
            s0_valid <= grant0 || grant1;
            s0_idx   <= grant1 ? req1_idx : req0_idx;
            s0_data  <= grant1 ? req1_data : req0_data;
        end
    end

    // Array write from stage 0; clear zeroes everything and drops the entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ELEM; i++) begin
                arr[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < N_ELEM; i++) begin
                arr[i] <= '0;
            end
        end else if (s0_valid) begin
            arr[s0_idx] <= s0_data;
        end
    end

    // Commit pulse and running update count; the count survives clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_valid <= 1'b0;
            commit_idx   <= '0;
            upd_count    <= 8'd0;
        end else begin
            commit_valid <= do_write;
            commit_idx   <= do_write ? s0_idx : '0;
            if (do_write) begin
                upd_count <= upd_count + 8'd1;
            end
        end
    end

    // Flatten the array onto the output bus, element i at slice i.
    for (genvar g = 0; g < N_ELEM; g++) begin : g_flat
        assign arr_out[g*ELEM_W +: ELEM_W] = arr[g];
    end

endmodule

// File: tb/tb_array_update_arbiter.sv
// Self-checking bench for array_update_arbiter: directed scenarios with
// literal expectations plus randomized traffic against a queue-based model.
module tb_array_update_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clear = 1'b0;
    logic         req0_valid = 1'b0;
    logic [1:0]   req0_idx = 2'd0;
    logic [32:0]  req0_data = 33'd0;
    logic         req0_ready;
    logic         req1_valid = 1'b0;
    logic [1:0]   req1_idx = 2'd0;
    logic [32:0]  req1_data = 33'd0;
    logic         req1_ready;
    logic [131:0] arr_out;
    logic         commit_valid;
    logic [1:0]   commit_idx;
    logic [7:0]   upd_count;

    int n_cmp = 0;
    int n_err = 0;

    array_update_arbiter #(.ELEM_W(33), .N_ELEM(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .req0_valid(req0_valid), .req0_idx(req0_idx), .req0_data(req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_idx(req1_idx), .req1_data(req1_data),
        .req1_ready(req1_ready),
        .arr_out(arr_out), .commit_valid(commit_valid),
        .commit_idx(commit_idx), .upd_count(upd_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [1:0]  idx;
        logic [32:0] data;
    } upd_t;

    upd_t        pend[$];
    logic [32:0] m_arr [4] = '{default: '0};
    int          m_prio = 0;
    int          m_cnt = 0;
    logic        m_cv = 1'b0;
    logic [1:0]  m_ci = 2'd0;
    logic        m_acc0 = 1'b0;
    logic        m_acc1 = 1'b0;

    // Who the rules say wins with the present inputs: -1 none, 0 or 1.
    function automatic int winner();
        if (!rst_n || clear) return -1;
        if (req0_valid && req1_valid) return m_prio;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int g;
        upd_t e;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_arr[i] = '0;
            pend.delete();
            m_prio = 0; m_cnt = 0; m_cv = 1'b0; m_ci = 2'd0;
            m_acc0 = 1'b0; m_acc1 = 1'b0;
        end else begin
            g = winner();
            m_cv = 1'b0;
            m_ci = 2'd0;
            if (clear) begin
                for (int i = 0; i < 4; i++) m_arr[i] = '0;
                pend.delete();
            end else if (pend.size() > 0) begin
                e = pend.pop_front();
                m_arr[e.idx] = e.data;
                m_cv = 1'b1;
                m_ci = e.idx;
                m_cnt = (m_cnt + 1) % 256;
            end
            if (g == 0) begin
                e.idx = req0_idx; e.data = req0_data;
                pend.push_back(e);
                m_prio = 1;
            end else if (g == 1) begin
                e.idx = req1_idx; e.data = req1_data;
                pend.push_back(e);
                m_prio = 0;
            end
            m_acc0 = (g == 0);
            m_acc1 = (g == 1);
        end
    end

    // Compare every cycle in mid-period, when inputs and outputs are stable.
    always @(negedge clk) begin
        logic [131:0] exp_arr;
        int g;
        g = winner();
        for (int i = 0; i < 4; i++) exp_arr[i*33 +: 33] = m_arr[i];
        chk("req0_ready", {131'd0, req0_ready}, {131'd0, g == 0});
        chk("req1_ready", {131'd0, req1_ready}, {131'd0, g == 1});
        chk("arr_out", arr_out, exp_arr);
        chk("commit_valid", {131'd0, commit_valid}, {131'd0, m_cv});
        chk("commit_idx", {130'd0, commit_idx}, {130'd0, m_ci});
        chk("upd_count", {124'd0, upd_count}, {124'd0, 8'(m_cnt)});
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0; clear = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    function automatic logic [32:0] rnd_data();
        return {1'($urandom_range(0, 1)), 32'($urandom)};
    endfunction

    initial begin
        logic [131:0] e;
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_arr", arr_out, 132'd0);
        chk("rst_cnt", {124'd0, upd_count}, 132'd0);
        chk("rst_commit", {131'd0, commit_valid}, 132'd0);

        // Single update, accepted on the first edge after release
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_idx = 2'd1; req0_data = 33'h2A;
        #1 chk("single_ready", {130'd0, req1_ready, req0_ready}, 132'b01);
        step();
        req0_valid = 1'b0;
        chk("single_latency", arr_out, 132'd0);
        @(posedge clk);
        #1;
        e = '0; e[65:33] = 33'h2A;
        chk("single_arr", arr_out, e);
        chk("single_commit", {129'd0, commit_valid, commit_idx}, {129'd0, 1'b1, 2'd1});
        chk("single_cnt", {124'd0, upd_count}, 132'd1);

        // Contention from a fresh pointer
        pulse_reset();
        req0_valid = 1'b1; req0_idx = 2'd0; req0_data = 33'd1;
        req1_valid = 1'b1; req1_idx = 2'd3; req1_data = 33'd2;
        for (int k = 0; k < 4; k++) begin
            #1 chk("rr_grant", {130'd0, req1_ready, req0_ready}, (k % 2) ? 132'b10 : 132'b01);
            step();
        end
        idle_inputs();
        step();
        step();
        e = '0; e[32:0] = 33'd1; e[131:99] = 33'd2;
        chk("rr_arr", arr_out, e);
        chk("rr_cnt", {124'd0, upd_count}, 132'd4);

        // Same index, back to back, last wins
        req0_valid = 1'b1; req0_idx = 2'd2; req0_data = 33'd5;
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_idx = 2'd2; req1_data = 33'd9;
        step();
        req1_valid = 1'b0;
        chk("same_first", {99'd0, arr_out[98:66]}, 132'd5);
        @(posedge clk);
        #1;
        e = '0; e[32:0] = 33'd1; e[98:66] = 33'd9; e[131:99] = 33'd2;
        chk("same_final", arr_out, e);
        chk("same_cnt", {124'd0, upd_count}, 132'd6);

        // Clear arriving on the edge that would have written
        #1;
        req0_valid = 1'b1; req0_idx = 2'd1; req0_data = 33'd7;
        step();
        clear = 1'b1;
        req1_valid = 1'b1; req1_idx = 2'd0; req1_data = 33'd3;
        #1 chk("clear_ready", {130'd0, req1_ready, req0_ready}, 132'd0);
        step();
        idle_inputs();
        chk("clear_arr", arr_out, 132'd0);
        chk("clear_commit", {131'd0, commit_valid}, 132'd0);
        chk("clear_cnt", {124'd0, upd_count}, 132'd6);
        step();
        chk("clear_drop", {123'd0, commit_valid, upd_count}, 132'd6);

        // Async reset with an update in flight
        req0_valid = 1'b1; req0_idx = 2'd3; req0_data = 33'h155;
        @(posedge clk);
        #3 rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        #1;
        chk("areset_now", {123'd0, commit_valid, upd_count}, 132'd0);
        chk("areset_ready", {130'd0, req1_ready, req0_ready}, 132'd0);
        step();
        rst_n = 1'b1;
        req1_valid = 1'b0;
        step();
        step();
        chk("areset_lost", arr_out, 132'd0);

        // Randomized traffic obeying the hold-until-accepted rule
        for (int c = 0; c < 600; c++) begin
            if (!req0_valid || m_acc0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_idx = 2'($urandom_range(0, 3));
                req0_data = rnd_data();
            end
            if (!req1_valid || m_acc1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_idx = 2'($urandom_range(0, 3));
                req1_data = rnd_data();
            end
            clear = ($urandom_range(0, 19) == 0);
            rst_n = 1'b1;
            if ($urandom_range(0, 99) == 0) begin
                #1 rst_n = 1'b0;
            end
            step();
        end
        idle_inputs();
        rst_n = 1'b1;
        step();

        // Counter wrap after 256 writes
        pulse_reset();
        for (int c = 0; c < 256; c++) begin
            req0_valid = 1'b1;
            req0_idx = 2'($urandom_range(0, 3));
            req0_data = rnd_data();
            step();
        end
        req0_valid = 1'b0;
        chk("wrap_255", {124'd0, upd_count}, 132'd255);
        step();
        chk("wrap_zero", {124'd0, upd_count}, 132'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/array_update_arbiter.md
ARRAY_UPDATE_ARBITER -- requirements
Module: array_update_arbiter

Interface
REQ-001 SHALL have parameters, one per line:
  ELEM_W, 33, width of one array element
  N_ELEM, 4, number of array elements (index width 2 bits)
REQ-002 SHALL have ports, one per line:
  clk  input  1  single clock, all state updates on rising edge
  rst_n  input  1  asynchronous active-low reset
  clear  input  1  synchronous clear of array and pending update
  req0_valid  input  1  requester 0 has an update
  req0_idx  input  2  requester 0 target element index
  req0_data  input  33  requester 0 new element value
  req0_ready  output  1  requester 0 update accepted this cycle
  req1_valid  input  1  requester 1 has an update
  req1_idx  input  2  requester 1 target element index
  req1_data  input  33  requester 1 new element value
  req1_ready  output  1  requester 1 update accepted this cycle
  arr_out  output  132  flattened array; element i at bits [33*i+32 : 33*i]
  commit_valid  output  1  one-cycle pulse: an update was written this cycle
  commit_idx  output  2  index written when commit_valid=1
  upd_count  output  8  total committed updates, wrapping
REQ-003 SHALL use one clock (clk) and an asynchronous active-low reset (rst_n); no other clock or reset.

Function
REQ-004 SHALL hold a 4 x 33-bit array register; arr_out SHALL be driven directly from it (no combinational path from request inputs).
REQ-005 SHALL accept at most one request per cycle; a request is accepted when reqK_valid=1 and reqK_ready=1 at a rising edge.
REQ-006 reqK_ready SHALL be combinational: 1 only for the granted requester; never both 1 in the same cycle.
REQ-007 Arbitration SHALL be round-robin with a 1-bit priority pointer: only one valid -> grant it; both valid -> grant the pointer's requester.
REQ-008 After any grant the pointer SHALL point to the non-granted requester; with no grant the pointer SHALL hold.
REQ-009 Accepted request SHALL be captured in stage-0 register (valid, idx, data) at edge N; the array element SHALL be written at edge N+1 (latency 2 edges from acceptance to arr_out change).
REQ-010 Pipeline SHALL never stall; accepts are allowed every cycle (full throughput, one update per cycle).
REQ-011 Back-to-back updates to the same index SHALL apply in acceptance order; last accepted value wins.
REQ-012 Only the addressed element SHALL change on a write; the other three SHALL keep their values.
REQ-013 commit_valid SHALL be a registered pulse, high for the cycle following the write edge, with commit_idx equal to the written index; commit_idx SHALL be 0 when commit_valid=0.
REQ-014 upd_count SHALL increment by 1 on each write, wrapping 255 -> 0.
REQ-015 clear=1 SHALL force both readys to 0, discard the stage-0 entry (no write, no count), zero all elements at that edge, and hold the pointer; upd_count SHALL NOT be cleared.
REQ-016 Requesters SHALL hold valid, idx and data stable until accepted; the block SHALL NOT depend on ready to drive valid.

Reset
REQ-017 On rst_n=0, immediately and regardless of clk: all array elements 0 (arr_out=0), stage-0 valid 0, pointer=requester 0, commit_valid=0, commit_idx=0, upd_count=0.
REQ-018 readys SHALL be 0 while rst_n=0; an update in flight when reset asserts SHALL be lost.
REQ-019 First edge after rst_n deassertion SHALL be able to accept a request.

Verification
REQ-020 Single update: after reset, req0 valid idx=1 data=0x2A for one accept -> req0_ready=1 that cycle; two edges later arr_out = {0,0,0x2A,0} (element 1 = 0x2A), commit_valid pulse with commit_idx=1, upd_count=1.
REQ-021 Contention: both valid every cycle, req0 idx=0 data=1, req1 idx=3 data=2 -> grants alternate 0,1,0,1 starting with req0; element0=1, element3=2; upd_count increments every cycle.
REQ-022 Same-index ordering: req0 writes idx=2 data=5, next cycle req1 writes idx=2 data=9 -> element2 reads 5 then 9; final 9; other elements unchanged.
REQ-023 Clear collision: update accepted at edge N, clear=1 at edge N+1 -> array all zero after N+1, no commit pulse, upd_count unchanged, readys 0 during clear.
REQ-024 Async reset mid-operation: rst_n low between edges with stage-0 valid -> arr_out=0, upd_count=0, commit_valid=0 immediately; pending update never written after release.
REQ-025 Counter wrap: 256 accepted updates -> upd_count returns to 0 on the 256th write.
